// File: rtl/mem_access_unit.sv
// Multicycle memory port between the control FSM and the unified instruction/data bus.
// Latency: minimum 3 cycles per access (request, bus cycle, done); each bus wait state adds one.
// Backpressure: stall is high while the request is pending or the bus is busy; the bus stalls via bus_ack.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   memory_read, memory_write,         access request from the control FSM
//   ir_write, lorD                     fetch select, address select (0 = pc, 1 = alu_out)
//   pc, alu_out, write_data            fetch address, data address, store data
//   bus_req/we/addr/wdata/be           registered bus request side
//   bus_rdata, bus_ack                 bus response (single-cycle ack)
//   instruction, instruction_opcode    instruction register and its opcode field
//   mdr                                formatted load data
//   stall, misaligned                  hold the FSM / aborted misaligned access pulse
module mem_access_unit #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic        ir_write,
  input  logic        lorD,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] write_data,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic [31:0] instruction,
  output logic [6:0]  instruction_opcode,
  output logic [31:0] mdr,
  output logic        stall,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Normalised size codes; any unlisted funct3 behaves as a word access.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic        lat_fetch;

  logic        req;
  logic        is_wr;
  logic        is_fetch;
  logic [31:0] addr;
  logic [2:0]  eff_f3;
  logic        is_byte;
  logic        is_half;
  logic        addr_bad;
  logic [3:0]  nxt_be;
  logic [31:0] nxt_wdata;
  logic [31:0] load_fmt;

  assign req                = memory_read | memory_write;
  // A write wins over a simultaneous read, so it can never be a fetch.
  assign is_wr              = memory_write;
  assign is_fetch           = ir_write & ~memory_write;
  assign addr               = lorD ? alu_out : pc;
  assign stall              = ((state == IDLE) && req) || (state == BUSY);
  assign instruction_opcode = instruction[6:0];

  always_comb begin
    eff_f3 = F3_W;
    if (!is_fetch) begin
      case (instruction[14:12])
        F3_B, F3_H, F3_BU, F3_HU: eff_f3 = instruction[14:12];
        default:                  eff_f3 = F3_W;
      endcase
    end
  end

  assign is_byte  = (eff_f3 == F3_B) || (eff_f3 == F3_BU);
  assign is_half  = (eff_f3 == F3_H) || (eff_f3 == F3_HU);
  assign addr_bad = (is_half && addr[0]) || (!is_byte && !is_half && (addr[1:0] != 2'b00));

  // Store lane steering; reads always enable every lane.
  always_comb begin
    nxt_be    = 4'b1111;
    nxt_wdata = write_data;
    if (is_wr) begin
      if (is_byte) begin
        nxt_be    = 4'b0001 << addr[1:0];
        nxt_wdata = {4{write_data[7:0]}};
      end else if (is_half) begin
        nxt_be    = addr[1] ? 4'b1100 : 4'b0011;
        nxt_wdata = {2{write_data[15:0]}};
      end
    end
  end

  // Load formatting uses the offset and size captured at request time.
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb       = bus_rdata[8*lat_off +: 8];
    lh       = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_fmt = bus_rdata;
    case (lat_f3)
      F3_B:    load_fmt = {{24{lb[7]}}, lb};
      F3_BU:   load_fmt = {24'h0, lb};
      F3_H:    load_fmt = {{16{lh[15]}}, lh};
      F3_HU:   load_fmt = {16'h0, lh};
      default: load_fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0;
      bus_wdata   <= 32'h0;
      bus_be      <= 4'h0;
      misaligned  <= 1'b0;
      instruction <= RESET_INSTR;
      mdr         <= 32'h0;
      lat_f3      <= F3_W;
      lat_off     <= 2'b00;
      lat_fetch   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (addr_bad) begin
              // Abort without touching the bus or any captured register.
              misaligned <= 1'b1;
              state      <= DONE;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= is_wr;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= nxt_wdata;
              bus_be    <= nxt_be;
              lat_f3    <= eff_f3;
              lat_off   <= addr[1:0];
              lat_fetch <= is_fetch;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (!bus_we) begin
              if (lat_fetch) instruction <= bus_rdata;
              else           mdr         <= load_fmt;
            end
            state <= DONE;
          end
        end
        DONE: begin
          // Requests still asserted here belong to the access just finished.
          misaligned <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory port sitting directly downstream of the control FSM. It consumes `memory_read`, `memory_write`, `ir_write` and `lorD`, runs a req/ack transaction on the unified instruction/data bus, and holds the instruction register (its opcode field drives the FSM) and the memory data register. It handles byte and halfword lanes, and asserts `stall` so the FSM holds its state and gates its write enables until the access completes.

## Interface
- `RESET_INSTR`, default 32'h0000_0013 (NOP): reset value of `instruction`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `memory_read` in 1: read request from the control FSM.
- `memory_write` in 1: write request from the control FSM.
- `ir_write` in 1: the current read is an instruction fetch; capture into the IR.
- `lorD` in 1: address select. 0 = `pc`, 1 = `alu_out`.
- `pc` in 32: fetch address.
- `alu_out` in 32: data address.
- `write_data` in 32: store data (rs2).
- `bus_rdata` in 32: bus read data, valid with `bus_ack`.
- `bus_ack` in 1: bus completion, single-cycle pulse.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: bus write enable, registered.
- `bus_addr` out 32: bus address, word aligned, registered.
- `bus_wdata` out 32: bus write data, lane-replicated, registered.
- `bus_be` out 4: bus byte enables, registered.
- `instruction` out 32: instruction register. `instruction_opcode` = `instruction[6:0]`.
- `mdr` out 32: memory data register, holding formatted load data.
- `stall` out 1: access in progress. The FSM must hold state and suppress writes.
- `misaligned` out 1: one-cycle pulse marking an aborted misaligned access.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - When `memory_read|memory_write` is high, latch the access and go to BUSY.
  - If the access is misaligned, go to DONE instead.
- BUSY: `bus_req`=1. On `bus_ack`, capture read data and go to DONE.
- DONE: one cycle, then IDLE. Requests present during DONE are ignored; they are the same FSM state finishing.
- `stall` = (IDLE & (rd|wr)) | BUSY. It is combinational from the request, and is 0 in DONE.
- Address and size:
  - Address is `lorD ? alu_out : pc`.
  - Fetch (`ir_write`=1) is always a word access.
  - Data access size comes from `instruction[14:12]`: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- `bus_addr` = {addr[31:2], 2'b00}.
- Store lanes:
  - SB: `bus_wdata`={4{wd[7:0]}}, `bus_be`=4'b0001<<addr[1:0].
  - SH: `bus_wdata`={2{wd[15:0]}}, `bus_be`=addr[1]?1100:0011.
  - SW: `bus_wdata`=wd, `bus_be`=1111.
- Reads: `bus_be`=1111 and `bus_we`=0.
- Load format: select the byte or halfword by addr[1:0]. B and H sign-extend; BU and HU zero-extend.
- Capture on ack:
  - `ir_write` latched → `instruction`<=`bus_rdata`.
  - Otherwise, a read → `mdr`<=formatted data.
  - A write captures nothing.
- Misaligned access: H with addr[0]=1, or W with addr[1:0]!=0.
  - No bus request is issued and no register changes.
  - `misaligned`=1 during the DONE cycle.
- Simultaneous `memory_read` and `memory_write`: the write is performed and the read is ignored.
- `bus_ack` outside BUSY is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `bus_req`, `bus_we`, `misaligned` = 0.
  - `bus_addr`, `bus_wdata`, `mdr` = 0; `bus_be`=0.
  - `instruction`=`RESET_INSTR`.
- Request seen in IDLE at cycle 0 → `bus_req` high from cycle 1.
- Ack at cycle k≥1 → `instruction`/`mdr` valid and `stall`=0 at cycle k+1 (DONE). The FSM advances at the end of k+1.
- Minimum access is 3 cycles (zero-wait ack in cycle 1). Each added wait state adds one cycle.
- `bus_req` drops in the cycle after ack.
- The latched address, data, size and kind stay stable while BUSY, even if inputs change.
- Misaligned access: `stall` is high in cycle 0 only. DONE and `misaligned` occur in cycle 1.
- Reset mid-BUSY:
  - `bus_req` drops immediately (async).
  - A later ack is ignored.
  - `instruction` returns to `RESET_INSTR`.

## Test plan
- Fetch, pc=0x100, zero-wait ack with `bus_rdata`=0x00500093 → `bus_addr`=0x100, `be`=1111, `instruction_opcode`=0x13, `stall` high for cycles 0–1, low in cycle 2.
- LB, addr=0x203, `bus_rdata`=0x80FF_1234, 2 wait states → `mdr`=0xFFFFFF80, `stall` low 4 cycles after the request. LBU on the same data → `mdr`=0x00000080.
- SH, addr=0x42, wd=0x1234_ABCD → `bus_addr`=0x40, `bus_wdata`=0xABCDABCD, `be`=1100, `we`=1; `mdr` unchanged.
- LW, addr=0x105 → no `bus_req`, `misaligned` pulse in cycle 1, `mdr` unchanged. SW at 0x104 afterwards proceeds normally.
- rst_n low while BUSY, then a stray ack → `bus_req`=0 immediately, state IDLE, `instruction`=0x13, ack ignored.
- Read and write asserted together, plus an ack while IDLE → only the write is issued; the idle ack causes no capture.
